// File: rtl/uart_autobaud_pkg.sv
// Shared definitions for the UART auto-baud configurator: FSM states,
// sync character, and measurement constants.
package uart_autobaud_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    WAIT_START,
    MEASURE,
    CHECK,
    LOCKED
  } ab_state_t;

  localparam logic [7:0]  SYNC_CHAR = 8'h55;
  localparam int unsigned TOL_SHIFT = 2;
  // 0x55 toggles on every bit, so start + data bits 0..6 give 8 intervals
  localparam int unsigned NUM_EDGES = 8;

endpackage

// File: rtl/uart_autobaud_if.sv
// Receiver-side link: divisor/enable out to the uart receiver, byte/error
// pulses back from it.
interface uart_autobaud_if;
  logic [31:0] clkdiv;
  logic        rx_en;
  logic        rx_recv;
  logic        rx_err;

  modport master (output clkdiv, rx_en, input rx_recv, rx_err);
  modport slave  (input clkdiv, rx_en, output rx_recv, rx_err);
endinterface

// File: rtl/uart_edge_timer.sv
// Interval timer for the sync character: flags rx edges while running and
// reports the cycles since the previous edge, a running total and a timeout.
module uart_edge_timer #(
  parameter int unsigned MAX_BIT = 65535,
  parameter int unsigned CW      = $clog2(MAX_BIT + 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  input  logic          start,
  input  logic          run,
  output logic          rx_edge,
  output logic [CW-1:0] interval,
  output logic [31:0]   total,
  output logic          timeout
);

  logic          rx_q;
  logic [CW-1:0] int_cnt;
  logic [31:0]   total_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q      <= 1'b1;
      int_cnt   <= '0;
      total_cnt <= '0;
    end else begin
      rx_q <= rx;
      if (start) begin
        int_cnt   <= CW'(1);
        total_cnt <= 32'd1;
      end else if (run) begin
        if (rx_edge)
          int_cnt <= CW'(1);
        else if (int_cnt != '1)
          int_cnt <= int_cnt + CW'(1);
        if (total_cnt != '1)
          total_cnt <= total_cnt + 32'd1;
      end
    end
  end

  assign rx_edge  = run && (rx != rx_q);
  assign timeout  = run && (int_cnt > CW'(MAX_BIT));
  assign interval = int_cnt;
  assign total    = total_cnt;

endmodule

// File: rtl/uart_autobaud.sv
// UART auto-baud configurator: times one 0x55 sync character, derives clkdiv,
// then supervises receiver framing errors and recalibrates when they persist.
module uart_autobaud
  import uart_autobaud_pkg::*;
#(
  parameter int unsigned IDLE_MIN    = 1024,
  parameter int unsigned MAX_BIT     = 65535,
  parameter int unsigned ERR_LIMIT   = 4,
  parameter logic [31:0] DEFAULT_DIV = 32'd103
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  input  logic                   recal,
  uart_autobaud_if.master        rxif,
  output logic                   locked,
  output logic                   cal_done,
  output logic                   cal_err
);

  localparam int unsigned CW = $clog2(MAX_BIT + 2);
  localparam int unsigned IW = $clog2(IDLE_MIN + 1);
  localparam int unsigned EW = $clog2(ERR_LIMIT + 1);

  ab_state_t     state, state_nxt;
  logic [IW-1:0] idle_cnt;
  logic [EW-1:0] err_cnt;
  logic [3:0]    edge_cnt;
  logic [CW-1:0] d [NUM_EDGES];
  logic [31:0]   total_cap;
  logic [31:0]   clkdiv_q;

  logic          tm_start, tm_run, rx_edge, timeout;
  logic [CW-1:0] interval;
  logic [31:0]   total;
  logic          accept, rx_en_s;
  logic [CW-1:0] tol, diff;

  uart_edge_timer #(.MAX_BIT(MAX_BIT), .CW(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .start    (tm_start),
    .run      (tm_run),
    .rx_edge  (rx_edge),
    .interval (interval),
    .total    (total),
    .timeout  (timeout)
  );

  // Every interval must sit within d0 +/- d0/4, and d0 must be long enough to trust
  always_comb begin
    tol    = d[0] >> TOL_SHIFT;
    diff   = '0;
    accept = (d[0] >= CW'(4));
    for (int unsigned i = 1; i < NUM_EDGES; i++) begin
      diff = (d[i] > d[0]) ? (d[i] - d[0]) : (d[0] - d[i]);
      if (diff > tol)
        accept = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= WAIT_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (recal) begin
      state_nxt = WAIT_IDLE;
    end else begin
      unique case (state)
        WAIT_IDLE:  if (rx && idle_cnt == IW'(IDLE_MIN - 1)) state_nxt = WAIT_START;
        WAIT_START: if (!rx) state_nxt = MEASURE;
        MEASURE: begin
          if (timeout)
            state_nxt = WAIT_IDLE;
          else if (rx_edge && edge_cnt == 4'(NUM_EDGES - 1))
            state_nxt = CHECK;
        end
        CHECK:      state_nxt = accept ? LOCKED : WAIT_IDLE;
        LOCKED:     if (rxif.rx_err && err_cnt >= EW'(ERR_LIMIT - 1)) state_nxt = WAIT_IDLE;
        default:    state_nxt = WAIT_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_en_s  = (state == LOCKED);
    tm_start = (state == WAIT_START) && !rx && !recal;
    tm_run   = (state == MEASURE);
    cal_done = (state == CHECK) && accept && !recal;
    cal_err  = !recal && (((state == CHECK) && !accept) ||
                          ((state == MEASURE) && timeout));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt  <= '0;
      err_cnt   <= '0;
      edge_cnt  <= '0;
      total_cap <= '0;
      clkdiv_q  <= DEFAULT_DIV;
      for (int unsigned i = 0; i < NUM_EDGES; i++)
        d[i] <= '0;
    end else begin
      if (state == WAIT_IDLE && rx && !recal) begin
        if (idle_cnt != '1)
          idle_cnt <= idle_cnt + IW'(1);
      end else begin
        idle_cnt <= '0;
      end

      if (state == LOCKED && state_nxt == LOCKED) begin
        if (rxif.rx_err) begin
          if (err_cnt != '1)
            err_cnt <= err_cnt + EW'(1);
        end else if (rxif.rx_recv) begin
          err_cnt <= '0;
        end
      end else begin
        err_cnt <= '0;
      end

      if (tm_start) begin
        edge_cnt <= '0;
      end else if (tm_run && rx_edge && !timeout && edge_cnt < 4'(NUM_EDGES)) begin
        d[edge_cnt[2:0]] <= interval;
        edge_cnt         <= edge_cnt + 4'd1;
        // Timer total keeps running past the last edge, so latch it here
        if (edge_cnt == 4'(NUM_EDGES - 1))
          total_cap <= total;
      end

      if (cal_done)
        clkdiv_q <= (total_cap >> $clog2(NUM_EDGES)) - 32'd1;
    end
  end

  assign rxif.clkdiv = clkdiv_q;
  assign rxif.rx_en  = rx_en_s;
  assign locked      = rx_en_s;

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: sync-character locks at several rates,
// rejection, timeout, error supervision and mid-measurement reset.
module tb_uart_autobaud;

  logic clk = 1'b0;
  logic rst, rx, recal;
  logic locked, cal_done, cal_err;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int d0, e0;

  uart_autobaud_if rxif();

  uart_autobaud #(
    .IDLE_MIN    (1024),
    .MAX_BIT     (65535),
    .ERR_LIMIT   (4),
    .DEFAULT_DIV (32'd103)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .recal    (recal),
    .rxif     (rxif),
    .locked   (locked),
    .cal_done (cal_done),
    .cal_err  (cal_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cal_done) done_cnt++;
    if (cal_err) err_cnt++;
    if (cal_done && cal_err) both_cnt++;
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic lvl, input int n);
    rx = lvl;
    repeat (n) tick();
  endtask

  task automatic idle(input int n);
    send_bit(1'b1, n);
  endtask

  // 0x55 framed LSB first; one frame slot may be given a different length
  task automatic send_sync(input int n, input int stretch_idx, input int stretch_len);
    logic [7:0] sc;
    logic       lvl;
    sc = 8'h55;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      lvl = 1'b0;
      else if (i == 9) lvl = 1'b1;
      else             lvl = sc[i-1];
      send_bit(lvl, (i == stretch_idx) ? stretch_len : n);
    end
  endtask

  task automatic pulse_recal();
    recal = 1'b1;
    tick();
    recal = 1'b0;
  endtask

  task automatic pulse_err();
    rxif.rx_err = 1'b1;
    tick();
    rxif.rx_err = 1'b0;
    tick();
  endtask

  task automatic pulse_recv();
    rxif.rx_recv = 1'b1;
    tick();
    rxif.rx_recv = 1'b0;
    tick();
  endtask

  task automatic lock_at(input string tag, input int n, input logic [31:0] exp_div);
    d0 = done_cnt;
    e0 = err_cnt;
    idle(1100);
    send_sync(n, -1, 0);
    expect_eq({tag, "_done"},   done_cnt - d0, 1);
    expect_eq({tag, "_err"},    err_cnt - e0, 0);
    expect_eq({tag, "_clkdiv"}, rxif.clkdiv, exp_div);
    expect_eq({tag, "_locked"}, locked, 1);
    expect_eq({tag, "_rx_en"},  rxif.rx_en, 1);
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    recal = 1'b0;
    rxif.rx_err = 1'b0;
    rxif.rx_recv = 1'b0;
    repeat (3) tick();
    expect_eq("rst_clkdiv",   rxif.clkdiv, 103);
    expect_eq("rst_rx_en",    rxif.rx_en, 0);
    expect_eq("rst_locked",   locked, 0);
    expect_eq("rst_cal_done", cal_done, 0);
    expect_eq("rst_cal_err",  cal_err, 0);
    rst = 1'b0;

    lock_at("lock104", 104, 103);

    pulse_recal();
    expect_eq("recal_locked", locked, 0);
    expect_eq("recal_rx_en",  rxif.rx_en, 0);
    lock_at("lock868", 868, 867);
    pulse_recal();
    lock_at("lock17", 17, 16);

    // data bit 3 stretched: 140 vs 104 is outside +/-26
    pulse_recal();
    d0 = done_cnt;
    e0 = err_cnt;
    idle(1100);
    send_sync(104, 4, 140);
    expect_eq("stretch_err",    err_cnt - e0, 1);
    expect_eq("stretch_done",   done_cnt - d0, 0);
    expect_eq("stretch_clkdiv", rxif.clkdiv, 16);
    expect_eq("stretch_locked", locked, 0);
    lock_at("relock104", 104, 103);

    // start bit held low beyond MAX_BIT
    pulse_recal();
    d0 = done_cnt;
    e0 = err_cnt;
    idle(1100);
    send_bit(1'b0, 66000);
    rx = 1'b1;
    tick();
    expect_eq("tmo_err",    err_cnt - e0, 1);
    expect_eq("tmo_done",   done_cnt - d0, 0);
    expect_eq("tmo_locked", locked, 0);
    expect_eq("tmo_clkdiv", rxif.clkdiv, 103);
    lock_at("lock17b", 17, 16);

    // framing-error supervision
    repeat (3) pulse_err();
    expect_eq("err3_locked", locked, 1);
    pulse_recv();
    repeat (3) pulse_err();
    expect_eq("err3b_locked", locked, 1);
    expect_eq("err3b_rx_en",  rxif.rx_en, 1);
    pulse_err();
    expect_eq("err4_locked", locked, 0);
    expect_eq("err4_rx_en",  rxif.rx_en, 0);
    expect_eq("err4_clkdiv", rxif.clkdiv, 16);

    // reset after 4 measured edges
    d0 = done_cnt;
    e0 = err_cnt;
    idle(1100);
    send_bit(1'b0, 104);
    send_bit(1'b1, 104);
    send_bit(1'b0, 104);
    send_bit(1'b1, 104);
    send_bit(1'b0, 10);
    rst = 1'b1;
    tick();
    expect_eq("mrst_clkdiv",   rxif.clkdiv, 103);
    expect_eq("mrst_rx_en",    rxif.rx_en, 0);
    expect_eq("mrst_locked",   locked, 0);
    expect_eq("mrst_cal_done", cal_done, 0);
    expect_eq("mrst_cal_err",  cal_err, 0);
    rst = 1'b0;
    rx = 1'b1;
    tick();
    expect_eq("mrst_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    lock_at("lock_after_rst", 104, 103);

    expect_eq("done_err_overlap", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_autobaud.md
Name: uart_autobaud

Overview:
- Baud-rate configurator and supervisor for the UART receive path.
- Measures one sync character (0x55) on the raw rx line and computes clkdiv for the receiver.
- Holds the receiver disabled while calibrating, then monitors its framing errors and forces recalibration after repeated errors.
- Sits between the rx pin synchronizer and the uart receiver; the receiver is reset by (rst | !rx_en).

Parameters:
- IDLE_MIN, 1024: consecutive high cycles on rx required before a start edge is accepted.
- MAX_BIT, 65535: maximum cycles allowed for any single measured bit interval. Exceeding it is a timeout.
- ERR_LIMIT, 4: consecutive rx_err frames that trigger recalibration.
- DEFAULT_DIV, 103: clkdiv value driven after reset and until the first lock.

Ports:
- clk  in  1  clock
- rst  in  1  reset. Synchronous, active-high.
- rx  in  1  rx line, already 2-flop synchronized to clk
- recal  in  1  single-cycle request to drop lock and recalibrate
- rx_recv  in  1  receiver byte-valid pulse
- rx_err  in  1  receiver framing-error pulse
- clkdiv  out  32  divisor to receiver. Bit period is clkdiv+1 cycles.
- rx_en  out  1  1 = receiver allowed to run
- locked  out  1  1 = clkdiv valid from a successful calibration
- cal_done  out  1  one-cycle pulse on successful lock
- cal_err  out  1  one-cycle pulse on a rejected measurement

Behaviour:
- Reset values: clkdiv=DEFAULT_DIV, rx_en=0, locked=0, cal_done=0, cal_err=0. State=WAIT_IDLE; all counters cleared.
- Reset mid-operation returns to these values on the next edge. Any partial measurement is discarded.
- WAIT_IDLE:
  - idle_cnt increments while rx=1 and clears when rx=0.
  - Transition to WAIT_START when idle_cnt reaches IDLE_MIN-1 with rx=1.
- WAIT_START: on rx=0 (falling edge, since the line was idle), go to MEASURE with edge_cnt=0, int_cnt=1, total=1.
- MEASURE:
  - Each cycle int_cnt and total increment.
  - On any change of rx relative to the previous cycle: store interval d[edge_cnt]=int_cnt, set int_cnt=1, edge_cnt++.
  - 0x55 framed LSB-first toggles every bit, so 8 intervals (d0..d7) span start bit through data bit 6. After the 8th edge, go to CHECK.
  - If int_cnt exceeds MAX_BIT: pulse cal_err and go to WAIT_IDLE.
- CHECK (1 cycle):
  - Accept iff every |d_i - d0| <= d0>>2 and d0 >= 4.
  - On accept: clkdiv = (total_at_8th_edge >> 3) - 1, using 32-bit unsigned arithmetic with the floor from the shift. Set locked=1, rx_en=1, pulse cal_done, go to LOCKED.
  - On reject: pulse cal_err, keep the old clkdiv, go to WAIT_IDLE.
  - The stop bit and the trailing idle are not measured; WAIT_IDLE naturally absorbs them.
- LOCKED:
  - err_cnt increments on rx_err and clears on rx_recv.
  - If err_cnt reaches ERR_LIMIT, or recal=1: locked=0, rx_en=0, err_cnt=0, go to WAIT_IDLE. clkdiv is retained.
  - rx_err and rx_recv in the same cycle: rx_err wins.
- rx_en=0 in every state except LOCKED. locked follows rx_en.
- recal outside LOCKED: restarts at WAIT_IDLE and clears idle_cnt.
- Counters saturate; none wraps.
- cal_done and cal_err are never asserted together.

Decomposition:
- Shared uart package holds:
  - the state encoding (WAIT_IDLE, WAIT_START, MEASURE, CHECK, LOCKED);
  - SYNC_CHAR=8'h55;
  - the tolerance shift constant (2).
- One sub-module, uart_edge_timer: detects rx edges, runs int_cnt/total with a MAX_BIT timeout, and emits an edge pulse with the interval value. The FSM and tolerance check stay in uart_autobaud.

Test Plan:
- Reset -> clkdiv=103, rx_en=0, locked=0. 1100 idle cycles, then 0x55 at 104 cycles/bit -> cal_done pulse, clkdiv=103, locked=1, rx_en=1.
- 0x55 at 868 cycles/bit -> clkdiv=867. Then 0x55 at 17 cycles/bit after recal -> clkdiv=16.
- 0x55 at 104 cycles/bit with bit 3 stretched to 140 cycles -> cal_err pulse, clkdiv unchanged, locked=0, next clean 0x55 locks.
- Start bit low for 70000 cycles -> cal_err pulse, return to WAIT_IDLE, no lock.
- Locked: 3 rx_err, 1 rx_recv, 3 rx_err -> stays locked. A 4th consecutive rx_err -> locked=0, rx_en=0, clkdiv retained.
- rst asserted mid-MEASURE after 4 edges -> next cycle all outputs at reset values. A following clean 0x55 at 104 cycles/bit -> clkdiv=103.
